// File: rtl/vadd_seq_ctrl.sv
// vadd_seq_ctrl
//   Top-level sequencer for the vector-add datapath. One start command runs
//   the whole job:
//     1. load A into BRAM through the stream wrapper
//     2. load B the same way
//     3. compute C[i] = A[i] + B[i] through compute port B
//     4. stream C back out through the wrapper
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               command pulse, only accepted while idle
//   base_a/b/c, vec_len job description, latched when start is accepted
//   busy, done, ovf     job status; ovf is sticky carry-out of any element sum
//   bram_start_write    one-cycle pulse: wrapper loads a vector from DMA
//   bram_start_read     one-cycle pulse: wrapper streams a vector to DMA
//   bram_base_addr      wrapper base address, valid with a start pulse
//   bram_len            wrapper length, valid with a start pulse
//   bram_done           wrapper completion pulse
//   comp_*_b            compute-side BRAM port (1-cycle read latency)
module vadd_seq_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [ADDR_WIDTH-1:0] base_c,
    input  logic [31:0]           vec_len,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic                  bram_start_write,
    output logic                  bram_start_read,
    output logic [ADDR_WIDTH-1:0] bram_base_addr,
    output logic [31:0]           bram_len,
    input  logic                  bram_done,
    output logic [ADDR_WIDTH-1:0] comp_addr_b,
    output logic [DATA_WIDTH-1:0] comp_din_b,
    input  logic [DATA_WIDTH-1:0] comp_dout_b,
    output logic                  comp_en_b,
    output logic                  comp_we_b
);

    typedef enum logic [3:0] {
        IDLE,
        LD_A_GO,
        LD_A_WAIT,
        LD_B_GO,
        LD_B_WAIT,
        C_RDA,
        C_RDB,
        C_WR,
        ST_GO,
        ST_WAIT,
        FIN
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] base_a_r;
    logic [ADDR_WIDTH-1:0] base_b_r;
    logic [ADDR_WIDTH-1:0] base_c_r;
    logic [31:0]           len_r;
    logic [31:0]           idx;
    logic [DATA_WIDTH-1:0] a_reg;

    logic [DATA_WIDTH:0]   sum;
    logic                  last;
    logic [ADDR_WIDTH-1:0] idx_addr;

    // During C_WR the port returns B[idx] (read issued in C_RDB).
    assign sum      = {1'b0, a_reg} + {1'b0, comp_dout_b};
    assign last     = (idx == len_r - 32'd1);
    // Address arithmetic is modulo 2^ADDR_WIDTH, so only the low idx bits matter.
    assign idx_addr = idx[ADDR_WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and decoded port/wrapper controls. Everything decodes to 0
    // in IDLE, so an asynchronous reset silences the outputs at once.
    always_comb begin
        state_nxt        = state;
        bram_start_write = 1'b0;
        bram_start_read  = 1'b0;
        bram_base_addr   = '0;
        bram_len         = '0;
        comp_en_b        = 1'b0;
        comp_we_b        = 1'b0;
        comp_addr_b      = '0;
        comp_din_b       = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (vec_len == 32'd0) ? FIN : LD_A_GO;
                end
            end
            LD_A_GO: begin
                bram_start_write = 1'b1;
                bram_base_addr   = base_a_r;
                bram_len         = len_r;
                state_nxt        = LD_A_WAIT;
            end
            LD_A_WAIT: begin
                if (bram_done) state_nxt = LD_B_GO;
            end
            LD_B_GO: begin
                bram_start_write = 1'b1;
                bram_base_addr   = base_b_r;
                bram_len         = len_r;
                state_nxt        = LD_B_WAIT;
            end
            LD_B_WAIT: begin
                if (bram_done) state_nxt = C_RDA;
            end
            C_RDA: begin
                comp_en_b   = 1'b1;
                comp_addr_b = base_a_r + idx_addr;
                state_nxt   = C_RDB;
            end
            C_RDB: begin
                comp_en_b   = 1'b1;
                comp_addr_b = base_b_r + idx_addr;
                state_nxt   = C_WR;
            end
            C_WR: begin
                comp_en_b   = 1'b1;
                comp_we_b   = 1'b1;
                comp_addr_b = base_c_r + idx_addr;
                comp_din_b  = sum[DATA_WIDTH-1:0];
                state_nxt   = last ? ST_GO : C_RDA;
            end
            ST_GO: begin
                bram_start_read = 1'b1;
                bram_base_addr  = base_c_r;
                bram_len        = len_r;
                state_nxt       = ST_WAIT;
            end
            ST_WAIT: begin
                if (bram_done) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job registers, element index, operand latch and status flags.
    // busy/done are registered so that done lands the cycle after FIN with
    // busy dropping on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_a_r <= '0;
            base_b_r <= '0;
            base_c_r <= '0;
            len_r    <= '0;
            idx      <= '0;
            a_reg    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (state == FIN) begin
                busy <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_a_r <= base_a;
                        base_b_r <= base_b;
                        base_c_r <= base_c;
                        len_r    <= vec_len;
                        idx      <= '0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                C_RDB: begin
                    // A[idx] arrives now, one cycle after the C_RDA read.
                    a_reg <= comp_dout_b;
                end
                C_WR: begin
                    if (sum[DATA_WIDTH]) begin
                        ovf <= 1'b1;
                    end
                    if (!last) begin
                        idx <= idx + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vadd_seq_ctrl.sv
module tb_vadd_seq_ctrl;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    logic [AW-1:0] base_c;
    logic [31:0]   vec_len;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          bram_start_write;
    logic          bram_start_read;
    logic [AW-1:0] bram_base_addr;
    logic [31:0]   bram_len;
    logic          bram_done;
    logic [AW-1:0] comp_addr_b;
    logic [DW-1:0] comp_din_b;
    logic [DW-1:0] comp_dout_b;
    logic          comp_en_b;
    logic          comp_we_b;

    vadd_seq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .base_a           (base_a),
        .base_b           (base_b),
        .base_c           (base_c),
        .vec_len          (vec_len),
        .busy             (busy),
        .done             (done),
        .ovf              (ovf),
        .bram_start_write (bram_start_write),
        .bram_start_read  (bram_start_read),
        .bram_base_addr   (bram_base_addr),
        .bram_len         (bram_len),
        .bram_done        (bram_done),
        .comp_addr_b      (comp_addr_b),
        .comp_din_b       (comp_din_b),
        .comp_dout_b      (comp_dout_b),
        .comp_en_b        (comp_en_b),
        .comp_we_b        (comp_we_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // BRAM contents (compute port) and reference copy.
    logic [DW-1:0] mem  [0:DEPTH-1];
    logic [DW-1:0] rmem [0:DEPTH-1];

    always @(posedge clk) begin
        if (comp_en_b) begin
            if (comp_we_b) mem[comp_addr_b] <= comp_din_b;
            comp_dout_b <= mem[comp_addr_b];
        end
    end

    // Wrapper model plus event logger, sampling on the falling edge.
    logic          done_m = 1'b0;
    logic          spur   = 1'b0;
    bit            pend   = 1'b0;
    int            cnt    = 0;
    int            w_cnt = 0, r_cnt = 0, en_cnt = 0, busy_cnt = 0, done_cnt = 0;
    int            rd_n = 0, wr_n = 0;
    logic [AW-1:0] wbase_prev = '0, wbase_last = '0, rbase_last = '0;
    logic [31:0]   wlen_last = '0, rlen_last = '0;
    logic [AW-1:0] rd_log [0:255];
    logic [AW-1:0] wr_log [0:255];

    assign bram_done = done_m | spur;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend   = 1'b0;
            done_m = 1'b0;
        end else begin
            done_m = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    done_m = 1'b1;
                    pend   = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (bram_start_write) begin
                w_cnt++;
                wbase_prev = wbase_last;
                wbase_last = bram_base_addr;
                wlen_last  = bram_len;
                pend = 1'b1;
                cnt  = int'($urandom_range(3, 0));
            end
            if (bram_start_read) begin
                r_cnt++;
                rbase_last = bram_base_addr;
                rlen_last  = bram_len;
                pend = 1'b1;
                cnt  = int'($urandom_range(3, 0));
            end
            if (comp_en_b) en_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (comp_en_b && !comp_we_b) begin
                rd_log[8'(rd_n)] = comp_addr_b;
                rd_n++;
            end
            if (comp_en_b && comp_we_b) begin
                wr_log[8'(wr_n)] = comp_addr_b;
                wr_n++;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {32'd0, busy, done, ovf, bram_start_write, bram_start_read, bram_base_addr,
                bram_len, comp_addr_b, comp_din_b, comp_en_b, comp_we_b};
    endfunction

    task automatic put(input logic [AW-1:0] addr, input logic [DW-1:0] v);
        mem[addr] <= v;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // mode 0: plain run; 1: stray start/bram_done injections; 2: reset in C_RDB
    task automatic run_op(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] c, input logic [31:0] len, input int mode);
        logic [DW:0]   s;
        logic [AW-1:0] ai, bi, ci;
        bit            ovf_exp = 1'b0;
        bit            got = 1'b0;
        int            w0, r0, d0;
        int            i1 = 0;
        bit            i2 = 1'b0, i3 = 1'b0;

        tick();
        for (int k = 0; k < DEPTH; k++) rmem[k] = mem[k];
        for (int i = 0; i < int'(len); i++) begin
            ai = a + AW'(i);
            bi = b + AW'(i);
            ci = c + AW'(i);
            s  = {1'b0, rmem[ai]} + {1'b0, rmem[bi]};
            rmem[ci] = s[DW-1:0];
            if (s[DW]) ovf_exp = 1'b1;
        end
        w0 = w_cnt; r0 = r_cnt; d0 = done_cnt;

        base_a = a; base_b = b; base_c = c; vec_len = len;
        start = 1'b1;
        for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
            tick();
            start = 1'b0;
            spur  = 1'b0;
            if (done) begin
                got = 1'b1;
            end else if (mode == 1) begin
                if (i1 == 1) begin
                    start = 1'b1;
                    i1 = 2;
                end else if (i1 == 0 && w_cnt - w0 == 2) begin
                    i1 = 1;
                end
                if (!i2 && comp_we_b) begin
                    start = 1'b1;
                    i2 = 1'b1;
                end
                if (!i3 && comp_en_b && !comp_we_b && comp_addr_b == b) begin
                    spur = 1'b1;
                    i3 = 1'b1;
                end
            end else if (mode == 2 && comp_en_b && !comp_we_b && comp_addr_b == b) begin
                rst_n = 1'b0;
                #1;
                check({tag, " outs_in_reset"}, all_outs(), 128'd0);
                tick();
                check({tag, " outs_held_reset"}, all_outs(), 128'd0);
                rst_n = 1'b1;
                tick();
                check({tag, " outs_after_reset"}, all_outs(), 128'd0);
                return;
            end
        end
        if (!got) begin
            check({tag, " done_timeout"}, 128'd0, 128'd1);
            return;
        end
        check({tag, " busy_at_done"}, 128'(busy), 128'd0);
        check({tag, " ovf"}, 128'(ovf), 128'(ovf_exp));
        check({tag, " n_start_write"}, 128'(w_cnt - w0), 128'd2);
        check({tag, " n_start_read"}, 128'(r_cnt - r0), 128'd1);
        check({tag, " base_a_load"}, 128'(wbase_prev), 128'(a));
        check({tag, " base_b_load"}, 128'(wbase_last), 128'(b));
        check({tag, " base_c_store"}, 128'(rbase_last), 128'(c));
        check({tag, " len_write"}, 128'(wlen_last), 128'(len));
        check({tag, " len_read"}, 128'(rlen_last), 128'(len));
        for (int i = 0; i < int'(len); i++) begin
            ci = c + AW'(i);
            check($sformatf("%s C[%0d]", tag, i), 128'(mem[ci]), 128'(rmem[ci]));
        end
        tick();
        check({tag, " done_single"}, 128'(done), 128'd0);
        check({tag, " done_count"}, 128'(done_cnt - d0), 128'd1);
    endtask

    initial begin
        int            rd0, wr0, w0, r0, e0, b0;
        logic [AW-1:0] ra, rb, rc;
        logic [31:0]   rl;

        rst_n = 1'b0; start = 1'b0;
        base_a = '0; base_b = '0; base_c = '0; vec_len = '0;
        #1;
        check("reset outs", all_outs(), 128'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("idle outs", all_outs(), 128'd0);

        // Basic 4-element add with known values.
        for (int i = 0; i < 4; i++) begin
            put(AW'(i), DW'(i + 1));
            put(AW'(16 + i), DW'(10 * (i + 1)));
        end
        wr0 = wr_n;
        run_op("basic", 13'd0, 13'd16, 13'd32, 32'd4, 0);
        check("basic C32", 128'(mem[32]), 128'd11);
        check("basic C33", 128'(mem[33]), 128'd22);
        check("basic C34", 128'(mem[34]), 128'd33);
        check("basic C35", 128'(mem[35]), 128'd44);
        for (int i = 0; i < 4; i++)
            check($sformatf("basic wr_order %0d", i), 128'(wr_log[8'(wr0 + i)]), 128'(32 + i));
        check("basic ovf", 128'(ovf), 128'd0);

        // Zero-length job.
        w0 = w_cnt; r0 = r_cnt; e0 = en_cnt; b0 = busy_cnt;
        base_a = 13'd5; base_b = 13'd6; base_c = 13'd7; vec_len = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len0 busy c1", 128'(busy), 128'd1);
        check("len0 done c1", 128'(done), 128'd0);
        tick();
        check("len0 done c2", 128'(done), 128'd1);
        check("len0 busy c2", 128'(busy), 128'd0);
        tick();
        check("len0 done c3", 128'(done), 128'd0);
        check("len0 n_write", 128'(w_cnt - w0), 128'd0);
        check("len0 n_read", 128'(r_cnt - r0), 128'd0);
        check("len0 en", 128'(en_cnt - e0), 128'd0);
        check("len0 busy_cycles", 128'(busy_cnt - b0), 128'd1);

        // Carry out, then cleared by the next clean job.
        put(13'd100, 32'hFFFF_FFFF);
        put(13'd200, 32'd2);
        run_op("ovf", 13'd100, 13'd200, 13'd300, 32'd1, 0);
        check("ovf C0", 128'(mem[300]), 128'd1);
        check("ovf set", 128'(ovf), 128'd1);
        put(13'd100, 32'd7);
        run_op("ovf_clr", 13'd100, 13'd200, 13'd300, 32'd1, 0);
        check("ovf cleared", 128'(ovf), 128'd0);

        // Address wrap on the compute port.
        put(13'd8190, 32'd1); put(13'd8191, 32'd2); put(13'd0, 32'd3);
        rd0 = rd_n;
        run_op("wrap", 13'd8190, 13'd50, 13'd60, 32'd3, 0);
        check("wrap rdA0", 128'(rd_log[8'(rd0 + 0)]), 128'd8190);
        check("wrap rdA1", 128'(rd_log[8'(rd0 + 2)]), 128'd8191);
        check("wrap rdA2", 128'(rd_log[8'(rd0 + 4)]), 128'd0);

        // Stray start and bram_done pulses must be ignored.
        for (int i = 0; i < 3; i++) begin
            put(AW'(400 + i), $urandom);
            put(AW'(500 + i), $urandom);
        end
        run_op("inject", 13'd400, 13'd500, 13'd600, 32'd3, 1);

        // Reset mid-compute, then a fresh job.
        run_op("rst_mid", 13'd700, 13'd800, 13'd900, 32'd3, 2);
        put(13'd1000, 32'd123); put(13'd1001, 32'd456);
        put(13'd1100, 32'd1000); put(13'd1101, 32'hFFFF_FFF0);
        run_op("post_rst", 13'd1000, 13'd1100, 13'd1200, 32'd2, 0);

        // Randomized jobs; regions may alias.
        for (int t = 0; t < 6; t++) begin
            ra = AW'($urandom);
            rb = AW'($urandom);
            rc = AW'($urandom);
            rl = 32'($urandom_range(8, 1));
            for (int i = 0; i < int'(rl); i++) begin
                put(ra + AW'(i), ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
                put(rb + AW'(i), 32'($urandom));
            end
            run_op($sformatf("rand%0d", t), ra, rb, rc, rl, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
